// File: rtl/ldst_burst_pkg.sv
// Shared encodings for the burst load/store unit: op codes, FSM states and
// the layout of the ldst_typ_sel field.
package ldst_burst_pkg;

    typedef enum logic [1:0] {
        LDST_LD  = 2'b00,
        LDST_LDB = 2'b01,
        LDST_ST  = 2'b10,
        LDST_STB = 2'b11
    } ldst_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_STORE
    } ldst_state_e;

    localparam int TYP_OP_LSB = 0;
    localparam int TYP_OP_MSB = 1;
    localparam int TYP_PINC   = 2;

    typedef struct packed {
        ldst_op_e op;
        logic     pinc;
    } ldst_req_t;

    function automatic logic is_burst(input ldst_op_e op);
        return (op == LDST_LDB) || (op == LDST_STB);
    endfunction

    function automatic logic is_store(input ldst_op_e op);
        return (op == LDST_ST) || (op == LDST_STB);
    endfunction

endpackage

// File: rtl/ldst_burst_ram.sv
// Single-port synchronous RAM, write-first, one-cycle read latency.
module single_ram_p #(
    parameter int DAT_W = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [DAT_W-1:0] wdata,
    output logic [DAT_W-1:0] rdata
);

    logic [DAT_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ldst_burst.sv
// Load/store unit with base register, auto-incrementing bursts and a
// registered load-result path; owns its single-port data RAM.
module ldst_burst
    import ldst_burst_pkg::*;
#(
    parameter int DAT_W = 32,
    parameter int AW    = 10,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             ldst_t_sel,
    input  logic [4:0]       ldst_typ_sel,
    input  logic [AW-1:0]    ldst_t_dat,
    input  logic [LEN_W-1:0] ldst_len,
    input  logic             ldst_o_bas_sel,
    input  logic [AW-1:0]    ldst_o_bas_dat,
    input  logic             ldst_o_sel,
    input  logic [DAT_W-1:0] ldst_o_dat,
    output logic             ldst_o_rdy,
    output logic [DAT_W-1:0] ldst_r_dat,
    output logic             ldst_r_vld,
    output logic             ldst_busy,
    output logic             ldst_done
);

    ldst_state_e      state;
    ldst_req_t        req;
    logic [AW-1:0]    base;
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] rem;
    logic             pinc;
    logic [1:0]       vld_pipe;
    logic             issue;
    logic             wr;
    logic [DAT_W-1:0] ram_q;
    logic             unused_typ;

    assign req = '{op:   ldst_op_e'(ldst_typ_sel[TYP_OP_MSB:TYP_OP_LSB]),
                   pinc: ldst_typ_sel[TYP_PINC]};
    assign unused_typ = ^ldst_typ_sel[4:3];

    // RAM accesses are gated by rst_b so a reset edge never commits a beat.
    assign issue      = rst_b && (state == ST_LOAD);
    assign wr         = rst_b && (state == ST_STORE) && ldst_o_sel;
    assign ldst_o_rdy = wr;
    assign ldst_r_vld = vld_pipe[1];

    single_ram_p #(
        .DAT_W(DAT_W),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .en   (issue | wr),
        .we   (wr),
        .addr (addr),
        .wdata(ldst_o_dat),
        .rdata(ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state      <= ST_IDLE;
            base       <= '0;
            addr       <= '0;
            rem        <= '0;
            pinc       <= 1'b0;
            vld_pipe   <= '0;
            ldst_r_dat <= '0;
            ldst_busy  <= 1'b0;
            ldst_done  <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[0], issue};
            ldst_done <= 1'b0;
            if (vld_pipe[0])
                ldst_r_dat <= ram_q;

            case (state)
                ST_IDLE: begin
                    if (ldst_o_bas_sel)
                        base <= ldst_o_bas_dat;
                    // Trigger samples the pre-update base even if bas_sel coincides.
                    if (ldst_t_sel) begin
                        addr      <= base + ldst_t_dat;
                        rem       <= is_burst(req.op) ? ldst_len : '0;
                        pinc      <= req.pinc;
                        ldst_busy <= 1'b1;
                        state     <= is_store(req.op) ? ST_STORE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    addr <= addr + AW'(1);
                    if (rem == '0)
                        state <= ST_DRAIN;
                    else
                        rem <= rem - LEN_W'(1);
                end
                ST_DRAIN: begin
                    // addr already points one past the last beat.
                    state     <= ST_IDLE;
                    ldst_busy <= 1'b0;
                    ldst_done <= 1'b1;
                    if (pinc)
                        base <= addr;
                end
                ST_STORE: begin
                    if (ldst_o_sel) begin
                        addr <= addr + AW'(1);
                        if (rem == '0) begin
                            state     <= ST_IDLE;
                            ldst_busy <= 1'b0;
                            ldst_done <= 1'b1;
                            if (pinc)
                                base <= addr + AW'(1);
                        end else begin
                            rem <= rem - LEN_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldst_burst.sv
// Bench for ldst_burst: directed table, corner sequences and random ops
// checked cycle by cycle against a word-array memory model.
module tb_ldst_burst;

    localparam int DAT_W = 32;
    localparam int AW    = 10;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             ldst_t_sel;
    logic [4:0]       ldst_typ_sel;
    logic [AW-1:0]    ldst_t_dat;
    logic [LEN_W-1:0] ldst_len;
    logic             ldst_o_bas_sel;
    logic [AW-1:0]    ldst_o_bas_dat;
    logic             ldst_o_sel;
    logic [DAT_W-1:0] ldst_o_dat;
    logic             ldst_o_rdy;
    logic [DAT_W-1:0] ldst_r_dat;
    logic             ldst_r_vld;
    logic             ldst_busy;
    logic             ldst_done;

    int vectors = 0;
    int miscompares = 0;

    logic [DAT_W-1:0] mem_m [1<<AW];
    logic [AW-1:0]    base_m;

    typedef struct {
        logic [AW-1:0]    wbase;
        logic [AW-1:0]    woff;
        logic [DAT_W-1:0] wdat;
        logic [AW-1:0]    rbase;
        logic [AW-1:0]    roff;
    } vec_t;
    vec_t tbl [5];

    ldst_burst #(.DAT_W(DAT_W), .AW(AW), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .ldst_t_sel    (ldst_t_sel),
        .ldst_typ_sel  (ldst_typ_sel),
        .ldst_t_dat    (ldst_t_dat),
        .ldst_len      (ldst_len),
        .ldst_o_bas_sel(ldst_o_bas_sel),
        .ldst_o_bas_dat(ldst_o_bas_dat),
        .ldst_o_sel    (ldst_o_sel),
        .ldst_o_dat    (ldst_o_dat),
        .ldst_o_rdy    (ldst_o_rdy),
        .ldst_r_dat    (ldst_r_dat),
        .ldst_r_vld    (ldst_r_vld),
        .ldst_busy     (ldst_busy),
        .ldst_done     (ldst_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_base(input logic [AW-1:0] v);
        ldst_o_bas_sel = 1'b1;
        ldst_o_bas_dat = v;
        tick();
        ldst_o_bas_sel = 1'b0;
        base_m = v;
    endtask

    // Runs one transfer from trigger to the done cycle and returns in the
    // done cycle, so the caller may trigger again immediately.
    task automatic do_op(input logic [1:0] op, input logic pinc, input logic [AW-1:0] off,
                         input logic [LEN_W-1:0] len, input int gap_pct,
                         input logic use_pat, input logic [31:0] pat,
                         input logic dfix, input logic [DAT_W-1:0] dbase,
                         input logic poke, input logic co_bas, input logic [AW-1:0] co_val);
        int n;
        int i;
        int k;
        logic [AW-1:0] start;
        logic [AW-1:0] a;
        n     = op[0] ? int'(len) + 1 : 1;
        start = base_m + off;
        ldst_t_sel     = 1'b1;
        ldst_typ_sel   = {2'($urandom), pinc, op};
        ldst_t_dat     = off;
        ldst_len       = len;
        ldst_o_bas_sel = co_bas;
        ldst_o_bas_dat = co_val;
        tick();
        ldst_t_sel     = 1'b0;
        ldst_o_bas_sel = 1'b0;
        if (co_bas)
            base_m = co_val;
        if (poke) begin
            ldst_t_sel     = 1'b1;
            ldst_typ_sel   = 5'($urandom);
            ldst_t_dat     = AW'($urandom);
            ldst_len       = LEN_W'($urandom);
            ldst_o_bas_sel = 1'b1;
            ldst_o_bas_dat = AW'($urandom);
        end
        if (!op[1]) begin
            for (int c = 1; c <= n + 2; c++) begin
                chk1("ld_busy", ldst_busy, c <= n + 1);
                chk1("ld_r_vld", ldst_r_vld, c >= 3);
                chk1("ld_done", ldst_done, c == n + 2);
                if (c >= 3) begin
                    a = start + AW'(c - 3);
                    chk("ld_r_dat", ldst_r_dat, mem_m[a]);
                end
                if (c < n + 2) begin
                    tick();
                    ldst_t_sel     = 1'b0;
                    ldst_o_bas_sel = 1'b0;
                end
            end
        end else begin
            i = 0;
            k = 0;
            while (i < n) begin
                if (k > 200)
                    ldst_o_sel = 1'b1;
                else if (use_pat)
                    ldst_o_sel = (k < 32) ? pat[k] : 1'b1;
                else
                    ldst_o_sel = ($urandom_range(99) >= gap_pct);
                ldst_o_dat = dfix ? dbase + DAT_W'(i) : $urandom;
                #1;
                chk1("st_o_rdy", ldst_o_rdy, ldst_o_sel);
                chk1("st_busy", ldst_busy, 1'b1);
                chk1("st_done", ldst_done, 1'b0);
                if (ldst_o_sel) begin
                    a = start + AW'(i);
                    mem_m[a] = ldst_o_dat;
                    i++;
                end
                k++;
                tick();
                ldst_t_sel     = 1'b0;
                ldst_o_bas_sel = 1'b0;
            end
            ldst_o_sel = 1'b0;
            chk1("st_done", ldst_done, 1'b1);
            chk1("st_busy_end", ldst_busy, 1'b0);
        end
        if (pinc)
            base_m = start + AW'(n);
    endtask

    task automatic ld(input logic [AW-1:0] off);
        do_op(2'b00, 1'b0, off, LEN_W'($urandom), 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        tbl[0] = '{wbase: 10'h010, woff: 10'h003, wdat: 32'hDEADBEEF, rbase: 10'h000, roff: 10'h013};
        tbl[1] = '{wbase: 10'h3FF, woff: 10'h002, wdat: 32'h0BADF00D, rbase: 10'h001, roff: 10'h000};
        tbl[2] = '{wbase: 10'h200, woff: 10'h200, wdat: 32'h12345678, rbase: 10'h3FF, roff: 10'h001};
        tbl[3] = '{wbase: 10'h123, woff: 10'h0AB, wdat: 32'hCAFEF00D, rbase: 10'h1CE, roff: 10'h000};
        tbl[4] = '{wbase: 10'h3FF, woff: 10'h3FF, wdat: 32'h55AA55AA, rbase: 10'h1FE, roff: 10'h200};

        rst_b = 1'b0;
        ldst_t_sel = 1'b1;
        ldst_typ_sel = 5'b00001;
        ldst_t_dat = '0;
        ldst_len = '0;
        ldst_o_bas_sel = 1'b0;
        ldst_o_bas_dat = '0;
        ldst_o_sel = 1'b1;
        ldst_o_dat = '0;
        tick();
        tick();
        chk("rst_r_dat", ldst_r_dat, '0);
        chk1("rst_r_vld", ldst_r_vld, 1'b0);
        chk1("rst_busy", ldst_busy, 1'b0);
        chk1("rst_done", ldst_done, 1'b0);
        chk1("rst_o_rdy", ldst_o_rdy, 1'b0);
        rst_b = 1'b1;
        ldst_t_sel = 1'b0;
        ldst_o_sel = 1'b0;
        base_m = '0;
        tick();

        // Fill the whole RAM so every later read has a known model value.
        for (int b = 0; b < 64; b++)
            do_op(2'b11, 1'b0, AW'(b * 16), 4'hF, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, '0);

        for (int t = 0; t < 5; t++) begin
            set_base(tbl[t].wbase);
            do_op(2'b10, 1'b0, tbl[t].woff, '0, 0, 1'b0, 0, 1'b1, tbl[t].wdat, 1'b0, 1'b0, '0);
            set_base(tbl[t].rbase);
            ld(tbl[t].roff);
            chk("tbl_r_dat", ldst_r_dat, tbl[t].wdat);
        end

        // Wrapping burst store then burst load.
        set_base(10'h3FE);
        do_op(2'b11, 1'b0, '0, 4'd3, 0, 1'b0, 0, 1'b1, 32'd1, 1'b0, 1'b0, '0);
        do_op(2'b01, 1'b0, '0, 4'd3, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, '0);
        chk("wrap_last", ldst_r_dat, 32'd4);
        set_base('0);
        ld(10'h000);
        chk("wrap_addr0", ldst_r_dat, 32'd3);
        ld(10'h001);
        chk("wrap_addr1", ldst_r_dat, 32'd4);

        // Gapped store, o_sel pattern 1,0,0,1,1,1.
        set_base(10'h050);
        do_op(2'b11, 1'b0, '0, 4'd3, 0, 1'b1, 32'b111001, 1'b1, 32'h100, 1'b0, 1'b0, '0);
        do_op(2'b01, 1'b0, '0, 4'd3, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, '0);
        chk("gap_last", ldst_r_dat, 32'h103);

        // Post-increment burst load, then a trigger on the done cycle.
        set_base(10'h020);
        do_op(2'b01, 1'b1, '0, 4'd7, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, '0);
        ld(10'h000);
        chk("pinc_r_dat", ldst_r_dat, mem_m[10'h028]);

        // Triggers and base writes during a transfer are ignored.
        set_base(10'h0C0);
        do_op(2'b01, 1'b0, 10'h004, 4'd5, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, '0);
        do_op(2'b11, 1'b0, 10'h008, 4'd3, 30, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, '0);
        ld(10'h000);
        chk("poke_base", ldst_r_dat, mem_m[10'h0C0]);

        // Base write coinciding with a trigger; then with a post-increment.
        do_op(2'b00, 1'b0, 10'h005, '0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 10'h300);
        ld(10'h000);
        chk("cobas_new", ldst_r_dat, mem_m[10'h300]);
        do_op(2'b01, 1'b1, 10'h002, 4'd2, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 10'h111);
        ld(10'h000);
        chk("cobas_pinc", ldst_r_dat, mem_m[10'h305]);

        // Store then load the same word back-to-back.
        do_op(2'b10, 1'b0, 10'h007, '0, 0, 1'b0, 0, 1'b1, 32'hA5A5_0007, 1'b0, 1'b0, '0);
        ld(10'h007);
        chk("st_then_ld", ldst_r_dat, 32'hA5A5_0007);

        // Reset during beat 1 of a 4-beat burst store.
        set_base(10'h100);
        do_op(2'b11, 1'b0, '0, 4'd3, 0, 1'b0, 0, 1'b1, 32'h7000, 1'b0, 1'b0, '0);
        ldst_t_sel = 1'b1;
        ldst_typ_sel = 5'b00011;
        ldst_t_dat = '0;
        ldst_len = 4'd3;
        tick();
        ldst_t_sel = 1'b0;
        ldst_o_sel = 1'b1;
        ldst_o_dat = 32'hBEEF_0000;
        tick();
        mem_m[10'h100] = 32'hBEEF_0000;
        ldst_o_dat = 32'hBEEF_0001;
        rst_b = 1'b0;
        tick();
        chk("mrst_r_dat", ldst_r_dat, '0);
        chk1("mrst_r_vld", ldst_r_vld, 1'b0);
        chk1("mrst_busy", ldst_busy, 1'b0);
        chk1("mrst_done", ldst_done, 1'b0);
        chk1("mrst_o_rdy", ldst_o_rdy, 1'b0);
        rst_b = 1'b1;
        ldst_o_sel = 1'b0;
        base_m = '0;
        tick();
        chk1("mrst_idle_busy", ldst_busy, 1'b0);
        set_base(10'h100);
        do_op(2'b01, 1'b0, '0, 4'd3, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, '0);
        chk("mrst_beat3", ldst_r_dat, 32'h7003);

        for (int r = 0; r < 40; r++) begin
            do_op(2'($urandom), ($urandom_range(3) == 0), AW'($urandom), LEN_W'($urandom),
                  $urandom_range(60), 1'b0, 0, 1'b0, 0, ($urandom_range(4) == 0),
                  ($urandom_range(4) == 0), AW'($urandom));
            if ($urandom_range(1) == 1)
                tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ldst_burst.md
Name: ldst_burst

Overview:
Parametrised next-generation load/store unit. It owns a base-address register, supports single and burst (auto-incrementing) transfers, and has a busy/valid handshake toward the datapath. It instantiates its own single-port synchronous data RAM. It replaces the fixed-width, single-access load/store wrapper in the ASIP datapath.

Parameters:
DAT_W, 32, data word width (bits)
AW, 10, data-memory address width; depth = 2**AW words
LEN_W, 4, burst-length field width; maximum burst = 2**LEN_W words

Ports:
clk  in  1  clock
rst_b  in  1  synchronous active-low reset
ldst_t_sel  in  1  trigger strobe; accepted only when ldst_busy=0
ldst_typ_sel  in  5  [1:0] op: 00 load, 01 burst load, 10 store, 11 burst store; [2] post-increment base; [4:3] reserved, ignored
ldst_t_dat  in  AW  address offset, added to the base register
ldst_len  in  LEN_W  burst length minus 1; ignored for single ops
ldst_o_bas_sel  in  1  load base register from ldst_o_bas_dat
ldst_o_bas_dat  in  AW  new base address
ldst_o_sel  in  1  store operand valid
ldst_o_dat  in  DAT_W  store operand
ldst_o_rdy  out  1  store operand consumed this cycle
ldst_r_dat  out  DAT_W  load result
ldst_r_vld  out  1  ldst_r_dat valid this cycle
ldst_busy  out  1  transfer in progress; triggers ignored
ldst_done  out  1  one-cycle pulse after the last beat completes

Behaviour:
- Reset (rst_b=0 at a clk edge): state=IDLE; base=0; ldst_r_dat=0; ldst_r_vld=0; ldst_busy=0; ldst_done=0; ldst_o_rdy=0. RAM contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. No further RAM writes or r_vld pulses occur after that edge.
- Address of beat i = (base + ldst_t_dat + i) mod 2**AW. Wrap-around is silent.
- Beat count = 1 for op 00/10; ldst_len+1 for op 01/11. ldst_len is captured at the trigger.
- States:
  - IDLE: on ldst_t_sel, capture op, address, and count, then go to LOAD (op 0x) or STORE (op 1x). ldst_busy=1 from the next cycle.
  - LOAD: issue one RAM read per cycle. The RAM has 1-cycle read latency and ldst_r_dat is registered. The beat-i result appears with ldst_r_vld=1 exactly 2 cycles after its issue cycle. After the last issue, go to DRAIN.
  - DRAIN: wait for the final result. ldst_r_vld=1 and ldst_done=1 on the same cycle; then go to IDLE.
  - STORE: ldst_o_rdy = ldst_o_sel (combinational). A write occurs only when ldst_o_sel=1; otherwise stall without advancing the address. ldst_done pulses the cycle after the last write; then go to IDLE.
- Single load: trigger at cycle T gives r_vld at T+3 (T+1 issue, T+2 RAM out, T+3 register). A burst of N gives r_vld on T+3 .. T+N+2, back-to-back.
- ldst_busy falls in the same cycle ldst_done pulses, so a new trigger can be accepted that cycle.
- Post-increment ([2]=1): when the transfer finishes, base <= base + ldst_t_dat + beat count (mod 2**AW).
- ldst_o_bas_sel is honoured only in IDLE. If it coincides with ldst_t_sel, the trigger uses the old base.
- If ldst_o_bas_sel coincides with a post-increment update, the post-increment wins.
- ldst_r_dat holds its last value when ldst_r_vld=0.
- Store-then-load to the same address returns the new data, because the single-port RAM serialises accesses.

Decomposition:
- Shared package (define.v): op encodings LDST_LD, LDST_LDB, LDST_ST, LDST_STB; state encodings; typ-field bit positions.
- One sub-module: single_ram_p (parameters DAT_W, AW): synchronous read and write, write-first, en/we active high.
- FSM, address generator, and base register stay in ldst_burst.

Test Plan:
- Reset, then base=0x010, store 0xDEADBEEF at offset 3, then single load at offset 3 -> write to address 0x013; ldst_r_dat=0xDEADBEEF at T+3; ldst_done pulses.
- Burst store len=3 at address 0x3FE, data 1..4 -> writes to 0x3FE, 0x3FF, 0x000, 0x001 (wrap). A burst load from the same address returns 1, 2, 3, 4 on 4 consecutive r_vld cycles.
- Burst store with ldst_o_sel gapped (1,0,0,1,1,1) -> exactly 4 writes; ldst_o_rdy mirrors ldst_o_sel; addresses advance only on accepted beats.
- Post-increment burst load, base=0x020, offset 0, len=7 -> base=0x028 afterward. A second trigger issued on the ldst_done cycle is accepted and reads 0x028.
- Trigger while ldst_busy=1, and ldst_o_bas_sel during a burst -> both ignored; base and transfer are unchanged.
- rst_b low on the second beat of a 4-beat burst store -> only beat 0 is written; all outputs are 0 the next cycle; state=IDLE.
